// File: rtl/rob_nway_pkg.sv
// rob_nway_pkg: shared defaults for the reorder buffer and its neighbours
// (rename, R-RAT). Widths derive from these in the modules that import it.
package rob_nway_pkg;
  localparam int PROJ_NUM_ARCH_REGS = 32;
  localparam int PROJ_NUM_PHYS_REGS = 64;
  localparam int ROB_SIZE           = 64;
  localparam int ROB_DISPATCH_W     = 2;
  localparam int ROB_COMMIT_W       = 2;
  localparam int ROB_WB_PORTS       = 2;
  localparam int PC_W               = 32;
endpackage

// File: rtl/rob_nway_commit_select.sv
// rob_nway_commit_select: combinational in-order scan of the CW entries at
// the ROB head.
//   vld/done/mp : per-lane entry state, lane 0 = head
//   retire      : lanes retiring this cycle (always a contiguous prefix)
//   cnt         : number of retiring lanes
//   flush_oh    : one-hot lane of the retiring mispredicted entry (if any)
//   flush       : a mispredicted entry retires this cycle
module rob_nway_commit_select #(
  parameter int CW = 2,
  localparam int LC = $clog2(CW + 1)
) (
  input  logic [CW-1:0] vld,
  input  logic [CW-1:0] done,
  input  logic [CW-1:0] mp,
  output logic [CW-1:0] retire,
  output logic [LC-1:0] cnt,
  output logic [CW-1:0] flush_oh,
  output logic          flush
);
  logic go;

  always_comb begin
    retire   = '0;
    cnt      = '0;
    flush_oh = '0;
    go       = 1'b1;
    for (int k = 0; k < CW; k++) begin
      if (go && vld[k] && done[k]) begin
        retire[k] = 1'b1;
        cnt       = cnt + 1'b1;
        // A mispredicted branch retires itself but nothing younger.
        if (mp[k]) begin
          flush_oh[k] = 1'b1;
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  assign flush = |flush_oh;
endmodule

// File: rtl/rob_nway.sv
// rob_nway: multi-issue reorder buffer.
//   Dispatch  : Disp_valid/pc/regupdate/arch/phys in, Disp_ready/Disp_tag out
//   Writeback : Wb_valid/tag/mispredict/target, per port
//   Commit    : registered Commit_valid/pc/regupdate/arch/phys per lane
//   Redirect  : registered one-cycle Flush pulse with Flush_pc
//   Status    : Count (registered), Full, Empty
// Head/tail wrap mod SIZE; Count disambiguates full from empty.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter int SIZE          = ROB_SIZE,
  parameter int DISPATCH_W    = ROB_DISPATCH_W,
  parameter int COMMIT_W      = ROB_COMMIT_W,
  parameter int WB_PORTS      = ROB_WB_PORTS,
  parameter int NUM_ARCH_REGS = PROJ_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = PROJ_NUM_PHYS_REGS,
  localparam int LA = $clog2(NUM_ARCH_REGS),
  localparam int LP = $clog2(NUM_PHYS_REGS),
  localparam int LT = $clog2(SIZE),
  localparam int LC = $clog2(COMMIT_W + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DISPATCH_W-1:0]    Disp_valid,
  input  logic [32*DISPATCH_W-1:0] Disp_pc,
  input  logic [DISPATCH_W-1:0]    Disp_regupdate,
  input  logic [LA*DISPATCH_W-1:0] Disp_arch,
  input  logic [LP*DISPATCH_W-1:0] Disp_phys,
  output logic                     Disp_ready,
  output logic [LT*DISPATCH_W-1:0] Disp_tag,
  input  logic [WB_PORTS-1:0]      Wb_valid,
  input  logic [LT*WB_PORTS-1:0]   Wb_tag,
  input  logic [WB_PORTS-1:0]      Wb_mispredict,
  input  logic [32*WB_PORTS-1:0]   Wb_target,
  output logic [COMMIT_W-1:0]      Commit_valid,
  output logic [32*COMMIT_W-1:0]   Commit_pc,
  output logic [COMMIT_W-1:0]      Commit_regupdate,
  output logic [LA*COMMIT_W-1:0]   Commit_arch,
  output logic [LP*COMMIT_W-1:0]   Commit_phys,
  output logic                     Flush,
  output logic [31:0]              Flush_pc,
  output logic [LT:0]              Count,
  output logic                     Full,
  output logic                     Empty
);
  logic [LT-1:0]   head, tail, head_nxt;
  logic [SIZE-1:0] ent_valid, ent_done, ent_mp, ent_ru;
  logic [31:0]     ent_pc     [SIZE];
  logic [31:0]     ent_target [SIZE];
  logic [LA-1:0]   ent_arch   [SIZE];
  logic [LP-1:0]   ent_phys   [SIZE];

  logic [COMMIT_W-1:0][LT-1:0] h_idx;
  logic [COMMIT_W-1:0] h_vld, h_done, h_mp, ret_mask, flush_oh;
  logic [LC-1:0]       ret_cnt_raw;
  logic [LT:0]         ret_cnt, disp_cnt;
  logic                flush_now, disp_fire;
  logic [31:0]         flush_tgt;

  assign Full       = (Count == (LT+1)'(SIZE));
  assign Empty      = (Count == '0);
  // No bypass from same-cycle retirement: readiness sees registered Count only.
  assign Disp_ready = ((LT+1)'(SIZE) - Count) >= (LT+1)'(DISPATCH_W);
  assign disp_fire  = Disp_ready && !flush_now;

  for (genvar i = 0; i < DISPATCH_W; i++) begin : g_tag
    assign Disp_tag[i*LT +: LT] = tail + LT'(i);
  end

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_head
    assign h_idx[k]  = head + LT'(k);
    assign h_vld[k]  = ent_valid[h_idx[k]];
    assign h_done[k] = ent_done[h_idx[k]];
    assign h_mp[k]   = ent_mp[h_idx[k]];
  end

  rob_nway_commit_select #(.CW(COMMIT_W)) u_sel (
    .vld      (h_vld),
    .done     (h_done),
    .mp       (h_mp),
    .retire   (ret_mask),
    .cnt      (ret_cnt_raw),
    .flush_oh (flush_oh),
    .flush    (flush_now)
  );

  assign ret_cnt  = (LT+1)'(ret_cnt_raw);
  assign head_nxt = head + LT'(ret_cnt_raw);

  always_comb begin
    disp_cnt = '0;
    if (disp_fire)
      for (int i = 0; i < DISPATCH_W; i++)
        if (Disp_valid[i]) disp_cnt = disp_cnt + 1'b1;
  end

  always_comb begin
    flush_tgt = '0;
    for (int k = 0; k < COMMIT_W; k++)
      if (flush_oh[k]) flush_tgt = ent_target[h_idx[k]];
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head             <= '0;
      tail             <= '0;
      Count            <= '0;
      ent_valid        <= '0;
      ent_done         <= '0;
      ent_mp           <= '0;
      Commit_valid     <= '0;
      Commit_pc        <= '0;
      Commit_regupdate <= '0;
      Commit_arch      <= '0;
      Commit_phys      <= '0;
      Flush            <= 1'b0;
      Flush_pc         <= '0;
    end else begin
      head         <= head_nxt;
      Commit_valid <= ret_mask;
      Flush        <= flush_now;
      Flush_pc     <= flush_now ? flush_tgt : '0;
      for (int k = 0; k < COMMIT_W; k++) begin
        Commit_pc[k*32 +: 32]     <= ret_mask[k] ? ent_pc[h_idx[k]]   : '0;
        Commit_regupdate[k]       <= ret_mask[k] && ent_ru[h_idx[k]];
        Commit_arch[k*LA +: LA]   <= ret_mask[k] ? ent_arch[h_idx[k]] : '0;
        Commit_phys[k*LP +: LP]   <= ret_mask[k] ? ent_phys[h_idx[k]] : '0;
      end
      if (flush_now) begin
        // Everything younger than the mispredict is squashed; dispatch and
        // writeback in this cycle are discarded.
        ent_valid <= '0;
        ent_done  <= '0;
        ent_mp    <= '0;
        tail      <= head_nxt;
        Count     <= '0;
      end else begin
        tail  <= tail + LT'(disp_cnt);
        Count <= Count + disp_cnt - ret_cnt;
        if (disp_fire)
          for (int i = 0; i < DISPATCH_W; i++)
            if (Disp_valid[i]) begin
              ent_valid[tail + LT'(i)] <= 1'b1;
              ent_done[tail + LT'(i)]  <= 1'b0;
              ent_mp[tail + LT'(i)]    <= 1'b0;
            end
        // Ascending port order: the higher port wins on a shared tag.
        for (int p = 0; p < WB_PORTS; p++)
          if (Wb_valid[p] && ent_valid[Wb_tag[p*LT +: LT]]) begin
            ent_done[Wb_tag[p*LT +: LT]] <= 1'b1;
            ent_mp[Wb_tag[p*LT +: LT]]   <= Wb_mispredict[p];
          end
        for (int k = 0; k < COMMIT_W; k++)
          if (ret_mask[k]) ent_valid[h_idx[k]] <= 1'b0;
      end
    end
  end

  // Payload fields carry no reset: they are only read behind valid/done.
  always_ff @(posedge CLK) begin
    if (disp_fire)
      for (int i = 0; i < DISPATCH_W; i++)
        if (Disp_valid[i]) begin
          ent_pc[tail + LT'(i)]   <= Disp_pc[i*32 +: 32];
          ent_ru[tail + LT'(i)]   <= Disp_regupdate[i];
          ent_arch[tail + LT'(i)] <= Disp_arch[i*LA +: LA];
          ent_phys[tail + LT'(i)] <= Disp_phys[i*LP +: LP];
        end
    if (!flush_now)
      for (int p = 0; p < WB_PORTS; p++)
        if (Wb_valid[p] && ent_valid[Wb_tag[p*LT +: LT]])
          ent_target[Wb_tag[p*LT +: LT]] <= Wb_target[p*32 +: 32];
  end
endmodule

// File: tb/tb_rob_nway.sv
module tb_rob_nway;
  localparam int DW = 2, CW = 2, WB = 2, LA = 5, LP = 6, LT = 6;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [DW-1:0]   Disp_valid = '0;
  logic [32*DW-1:0] Disp_pc = '0;
  logic [DW-1:0]   Disp_regupdate = '0;
  logic [LA*DW-1:0] Disp_arch = '0;
  logic [LP*DW-1:0] Disp_phys = '0;
  logic            Disp_ready;
  logic [LT*DW-1:0] Disp_tag;
  logic [WB-1:0]   Wb_valid = '0;
  logic [LT*WB-1:0] Wb_tag = '0;
  logic [WB-1:0]   Wb_mispredict = '0;
  logic [32*WB-1:0] Wb_target = '0;
  logic [CW-1:0]   Commit_valid;
  logic [32*CW-1:0] Commit_pc;
  logic [CW-1:0]   Commit_regupdate;
  logic [LA*CW-1:0] Commit_arch;
  logic [LP*CW-1:0] Commit_phys;
  logic            Flush;
  logic [31:0]     Flush_pc;
  logic [LT:0]     Count;
  logic            Full, Empty;

  int checks = 0;
  int errors = 0;

  rob_nway dut (
    .CLK(CLK), .RESET(RESET),
    .Disp_valid(Disp_valid), .Disp_pc(Disp_pc), .Disp_regupdate(Disp_regupdate),
    .Disp_arch(Disp_arch), .Disp_phys(Disp_phys), .Disp_ready(Disp_ready),
    .Disp_tag(Disp_tag), .Wb_valid(Wb_valid), .Wb_tag(Wb_tag),
    .Wb_mispredict(Wb_mispredict), .Wb_target(Wb_target),
    .Commit_valid(Commit_valid), .Commit_pc(Commit_pc),
    .Commit_regupdate(Commit_regupdate), .Commit_arch(Commit_arch),
    .Commit_phys(Commit_phys), .Flush(Flush), .Flush_pc(Flush_pc),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #2 RESET = 1'b0;
    #2;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_empty", 64'(Empty), 64'd1);
    check("rst_full", 64'(Full), 64'd0);
    check("rst_ready", 64'(Disp_ready), 64'd1);
    check("rst_cvalid", 64'(Commit_valid), 64'd0);
    check("rst_cpc", Commit_pc, 64'd0);
    check("rst_flush", 64'({Flush, Flush_pc}), 64'd0);
    check("rst_tag", 64'(Disp_tag), 64'({6'd1, 6'd0}));
    #19 RESET = 1'b1;
    step();

    // Basic dispatch of two, writeback of both, dual commit
    Disp_valid = 2'b11; Disp_pc = {32'h104, 32'h100}; Disp_regupdate = 2'b11;
    Disp_arch = {5'd3, 5'd2}; Disp_phys = {6'd11, 6'd10};
    step();
    Disp_valid = '0;
    check("b_count2", 64'(Count), 64'd2);
    check("b_empty0", 64'(Empty), 64'd0);
    Wb_valid = 2'b11; Wb_tag = {6'd1, 6'd0};
    step();
    Wb_valid = '0;
    step();
    check("b_cvalid", 64'(Commit_valid), 64'h3);
    check("b_cpc", Commit_pc, {32'h104, 32'h100});
    check("b_carch", 64'(Commit_arch), 64'({5'd3, 5'd2}));
    check("b_cphys", 64'(Commit_phys), 64'({6'd11, 6'd10}));
    check("b_cru", 64'(Commit_regupdate), 64'h3);
    check("b_count0", 64'(Count), 64'd0);
    step();
    check("b_cvalid_idle", 64'(Commit_valid), 64'd0);

    // Out-of-order writeback: younger done first blocks nothing past head
    check("o_tag", 64'(Disp_tag), 64'({6'd3, 6'd2}));
    Disp_valid = 2'b11; Disp_pc = {32'h10C, 32'h108};
    step();
    Disp_valid = '0;
    Wb_valid = 2'b01; Wb_tag = {6'd0, 6'd3};
    step();
    Wb_valid = '0;
    step();
    check("o_nocommit", 64'(Commit_valid), 64'd0);
    check("o_count", 64'(Count), 64'd2);
    Wb_valid = 2'b10; Wb_tag = {6'd2, 6'd0};
    step();
    Wb_valid = '0;
    step();
    check("o_cvalid", 64'(Commit_valid), 64'h3);
    check("o_cpc", Commit_pc, {32'h10C, 32'h108});

    // Fill to capacity (tail starts at 4, so tags wrap through 63->0)
    for (int n = 0; n < 32; n++) begin
      Disp_valid = 2'b11;
      Disp_pc = {32'h1004 + 32'(8 * n), 32'h1000 + 32'(8 * n)};
      step();
    end
    check("f_count", 64'(Count), 64'd64);
    check("f_full", 64'(Full), 64'd1);
    check("f_ready", 64'(Disp_ready), 64'd0);
    Disp_pc = {32'hDEAD, 32'hBEEF};
    step();
    Disp_valid = '0;
    check("f_drop", 64'(Count), 64'd64);
    Wb_valid = 2'b11; Wb_tag = {6'd5, 6'd4};
    step();
    Wb_valid = '0;
    step();
    check("f_cpc", Commit_pc, {32'h1004, 32'h1000});
    check("f_count62", 64'(Count), 64'd62);
    check("f_ready1", 64'(Disp_ready), 64'd1);
    check("f_full0", 64'(Full), 64'd0);
    check("f_tag", 64'(Disp_tag), 64'({6'd5, 6'd4}));

    // Asynchronous reset mid-stream
    RESET = 1'b0;
    #1;
    check("ar_cvalid", 64'(Commit_valid), 64'd0);
    check("ar_count", 64'(Count), 64'd0);
    check("ar_empty", 64'(Empty), 64'd1);
    check("ar_cpc", Commit_pc, 64'd0);
    check("ar_tag", 64'(Disp_tag), 64'({6'd1, 6'd0}));
    #2 RESET = 1'b1;
    step();

    // Mispredict at head with younger entries already done
    for (int n = 0; n < 3; n++) begin
      Disp_valid = 2'b11;
      Disp_pc = {32'h304 + 32'(8 * n), 32'h300 + 32'(8 * n)};
      step();
    end
    Disp_valid = '0;
    Wb_valid = 2'b11; Wb_tag = {6'd2, 6'd1};
    step();
    Wb_tag = {6'd4, 6'd3};
    step();
    Wb_valid = 2'b01; Wb_tag = {6'd0, 6'd5};
    step();
    Wb_valid = '0;
    step();
    check("m_nocommit", 64'(Commit_valid), 64'd0);
    check("m_count6", 64'(Count), 64'd6);
    Wb_valid = 2'b10; Wb_tag = {6'd0, 6'd0}; Wb_mispredict = 2'b10;
    Wb_target = {32'h200, 32'h0};
    step();
    Wb_valid = '0; Wb_mispredict = '0;
    Disp_valid = 2'b11; Disp_pc = {32'hBAD4, 32'hBAD0};
    step();
    Disp_valid = '0;
    check("m_cvalid", 64'(Commit_valid), 64'h1);
    check("m_cpc", Commit_pc, {32'h0, 32'h300});
    check("m_flush", 64'(Flush), 64'd1);
    check("m_flushpc", 64'(Flush_pc), 64'h200);
    check("m_count0", 64'(Count), 64'd0);
    check("m_empty", 64'(Empty), 64'd1);
    check("m_tag", 64'(Disp_tag), 64'({6'd2, 6'd1}));
    step();
    check("m_pulse", 64'(Flush), 64'd0);
    check("m_squash1", 64'(Commit_valid), 64'd0);
    step();
    check("m_squash2", 64'(Commit_valid), 64'd0);
    check("m_count_hold", 64'(Count), 64'd0);

    // Writeback to an unallocated tag
    Wb_valid = 2'b01; Wb_tag = {6'd0, 6'd7};
    step();
    Wb_valid = '0;
    step();
    check("u_cvalid", 64'(Commit_valid), 64'd0);
    check("u_count", 64'(Count), 64'd0);
    check("u_flush", 64'(Flush), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
